// File: rtl/seg_disp_ctrl.sv
// Seven-segment display word controller: MMIO DATA/MODE registers, hex pass-through
// or binary-to-BCD (double-dabble) conversion feeding the digit scanner.

module seg_disp_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_sel,
    input  logic        io_we,
    input  logic        io_addr,
    input  logic [31:0] io_wdata,
    input  logic        busy,
    output logic [31:0] io_rdata,
    output logic        wr_trig,
    output logic [31:0] data_post,
    output logic        mode_post
);

    logic [31:0] data_q, data_d;
    logic        mode_q, mode_d;
    logic        wr_en;

    always_comb begin
        wr_en  = io_sel & io_we;
        data_d = data_q;
        mode_d = mode_q;
        if (wr_en && !io_addr) begin
            data_d = io_wdata;
        end
        if (wr_en && io_addr) begin
            mode_d = io_wdata[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            mode_q <= 1'b0;
        end else begin
            data_q <= data_d;
            mode_q <= mode_d;
        end
    end

    // The display is re-evaluated from the values the write is about to store.
    assign wr_trig   = wr_en;
    assign data_post = data_d;
    assign mode_post = mode_d;
    assign io_rdata  = io_addr ? {30'b0, busy, mode_q} : data_q;

endmodule

// state | meaning
// IDLE  | display word stable, waiting for a register write
// CONV  | double-dabble in progress, one bit per cycle, 27 cycles
module seg_disp_ctrl #(
    parameter logic [31:0] ERR_PATTERN = 32'hEEEE_EEEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_sel,
    input  logic        io_we,
    input  logic        io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        busy,
    output logic [31:0] disp_out,
    output logic        disp_upd
);

    localparam logic [31:0] DEC_MAX   = 32'd99_999_999;
    localparam logic [4:0]  LAST_ITER = 5'd26;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [26:0] shift_q, shift_d;
    logic [31:0] bcd_q, bcd_d;
    logic [4:0]  iter_q, iter_d;
    logic [31:0] disp_q, disp_d;
    logic        upd_q, upd_d;

    logic        wr_trig;
    logic [31:0] data_post;
    logic        mode_post;
    logic [31:0] bcd_adj;
    logic [31:0] bcd_step;

    seg_disp_regs u_regs (
        .clk       (clk),
        .rst       (rst),
        .io_sel    (io_sel),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .busy      (busy),
        .io_rdata  (io_rdata),
        .wr_trig   (wr_trig),
        .data_post (data_post),
        .mode_post (mode_post)
    );

    // Per-nibble +3 correction; 4-bit wrap is safe since a nibble never exceeds 9 here.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 8; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end
        bcd_step = {bcd_adj[30:0], shift_q[26]};
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        disp_d  = disp_q;
        upd_d   = 1'b0;

        if (wr_trig) begin
            // Any write aborts a running conversion and restarts from the new values.
            if (!mode_post) begin
                disp_d  = data_post;
                upd_d   = 1'b1;
                state_d = IDLE;
            end else if (data_post > DEC_MAX) begin
                disp_d  = ERR_PATTERN;
                upd_d   = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = CONV;
                shift_d = data_post[26:0];
                bcd_d   = '0;
                iter_d  = '0;
            end
        end else if (state_q == CONV) begin
            bcd_d   = bcd_step;
            shift_d = {shift_q[25:0], 1'b0};
            iter_d  = iter_q + 5'd1;
            if (iter_q == LAST_ITER) begin
                disp_d  = bcd_step;
                upd_d   = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            disp_q  <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            disp_q  <= disp_d;
            upd_q   <= upd_d;
        end
    end

    assign busy     = (state_q == CONV);
    assign disp_out = disp_q;
    assign disp_upd = upd_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Bench for seg_disp_ctrl: directed and random register writes checked against a
// decimal-arithmetic model of the expected display word and conversion timing.

module tb_seg_disp_ctrl;

    localparam logic [31:0] ERR = 32'hEEEE_EEEE;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        io_sel = 1'b0;
    logic        io_we = 1'b0;
    logic        io_addr = 1'b1;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic        busy;
    logic [31:0] disp_out;
    logic        disp_upd;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_data = '0;
    logic        m_mode = 1'b0;
    logic [31:0] m_disp = '0;

    seg_disp_ctrl #(.ERR_PATTERN(ERR)) dut (
        .clk      (clk),
        .rst      (rst),
        .io_sel   (io_sel),
        .io_we    (io_we),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .busy     (busy),
        .disp_out (disp_out),
        .disp_upd (disp_upd)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic do_write(input logic a, input logic [31:0] d);
        @(negedge clk);
        io_sel   = 1'b1;
        io_we    = 1'b1;
        io_addr  = a;
        io_wdata = d;
        @(posedge clk);
        #1;
        io_sel  = 1'b0;
        io_we   = 1'b0;
        io_addr = 1'b1;
        #1;
    endtask

    // Writes, then follows the display through to its final value; abort_at > 0 returns
    // early so the next write lands on that busy cycle.
    task automatic write_and_check(input logic a, input logic [31:0] d, input int abort_at);
        logic [31:0] exp;
        bit          conv;
        if (a) m_mode = d[0];
        else   m_data = d;
        conv = m_mode && (m_data <= 32'd99_999_999);
        exp  = !m_mode ? m_data : (conv ? to_bcd(m_data) : ERR);
        do_write(a, d);
        if (!conv) begin
            check("disp_load", disp_out, exp);
            check("upd_pulse", 32'(disp_upd), 32'd1);
            check("busy_idle", 32'(busy), 32'd0);
            @(posedge clk);
            #2;
            check("upd_clear", 32'(disp_upd), 32'd0);
            m_disp = exp;
        end else begin
            check("busy_start", 32'(busy), 32'd1);
            check("disp_hold0", disp_out, m_disp);
            check("rd_status", io_rdata, {30'b0, 1'b1, m_mode});
            for (int i = 1; i <= 27; i++) begin
                if (abort_at > 0 && i == abort_at) return;
                @(posedge clk);
                #2;
                if (i < 27) begin
                    check("busy_conv", 32'(busy), 32'd1);
                    check("disp_hold", disp_out, m_disp);
                    check("upd_quiet", 32'(disp_upd), 32'd0);
                end else begin
                    check("dec_result", disp_out, exp);
                    check("busy_done", 32'(busy), 32'd0);
                    check("upd_done", 32'(disp_upd), 32'd1);
                end
            end
            @(posedge clk);
            #2;
            check("upd_clear", 32'(disp_upd), 32'd0);
            m_disp = exp;
        end
    endtask

    initial begin
        logic [31:0] v;
        logic        a;

        #3;
        check("rst_disp", disp_out, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_upd", 32'(disp_upd), 32'd0);
        check("rst_rd1", io_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        write_and_check(1'b0, 32'h1234_ABCD, 0);

        @(negedge clk);
        io_sel = 1'b0; io_we = 1'b1; io_addr = 1'b0; io_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        io_sel = 1'b1; io_we = 1'b0;
        @(posedge clk); #1;
        io_sel = 1'b0; io_we = 1'b0;
        #1;
        check("nowr_data", io_rdata, m_data);
        check("nowr_disp", disp_out, m_disp);
        check("nowr_upd", 32'(disp_upd), 32'd0);
        check("nowr_busy", 32'(busy), 32'd0);

        write_and_check(1'b1, 32'h0000_0001, 0);
        write_and_check(1'b0, 32'd12_345_678, 0);
        write_and_check(1'b0, 32'd99_999_999, 0);
        write_and_check(1'b0, 32'd100_000_000, 0);
        write_and_check(1'b0, 32'd0, 0);

        write_and_check(1'b0, 32'd12_345_678, 10);
        write_and_check(1'b0, 32'd5, 0);

        write_and_check(1'b1, 32'h0000_0000, 0);
        write_and_check(1'b0, 32'h0000_002A, 0);
        write_and_check(1'b1, 32'hFFFF_FFF1, 0);
        write_and_check(1'b1, 32'h0000_0000, 0);

        for (int n = 0; n < 14; n++) begin
            a = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = $urandom_range(0, 99_999_999);
                2:       v = $urandom_range(99_999_990, 100_000_009);
                default: v = $urandom_range(0, 999);
            endcase
            write_and_check(a, v, (n % 5 == 4) ? int'($urandom_range(1, 26)) : 0);
        end

        write_and_check(1'b1, 32'h0000_0001, 0);
        write_and_check(1'b0, 32'd12_345_678, 5);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_disp", disp_out, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_upd", 32'(disp_upd), 32'd0);
        check("midrst_rd1", io_rdata, 32'd0);
        io_addr = 1'b0;
        #1;
        check("midrst_rd0", io_rdata, 32'd0);
        io_addr = 1'b1;
        rst = 1'b1;
        m_data = '0; m_mode = 1'b0; m_disp = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            check("postrst_busy", 32'(busy), 32'd0);
            check("postrst_disp", disp_out, 32'd0);
        end
        write_and_check(1'b0, 32'h0BAD_F00D, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
